ahbl_slave_mux: RTL

Parametrised single-master AHB-Lite address decoder and slave multiplexer for the SoC bus. It replaces the fixed 15-port interconnect and adds:
- a configurable slave count and address map;
- a per-slave enable mask;
- true per-slave HRESP pass-through;
- an internal default slave that returns the two-cycle AHB-Lite ERROR response for unmapped or disabled regions.

It sits between the core's AHB-Lite master port and the peripheral/memory slaves.

---
 rtl/ahbl_slave_mux_pkg.sv | 27 ++
 rtl/ahbl_default_slave.sv | 51 +++++
 rtl/ahbl_slave_mux.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ahbl_slave_mux_pkg.sv
// Shared AHB-Lite types and constants for the slave multiplexer and its default slave.
package ahbl_slave_mux_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'b00,
    DEF_ERR1 = 2'b01,
    DEF_ERR2 = 2'b10
  } def_state_e;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no transfer.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave: answers every accepted transfer with the two-cycle AHB-Lite ERROR response.
module ahbl_default_slave
  import ahbl_slave_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       hsel,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic       err_hready,
  output logic       err_hresp,
  output def_state_e state
);

  logic take;
  assign take = hsel & is_active(htrans) & hready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= DEF_IDLE;
      err_hready <= 1'b1;
      err_hresp  <= HRESP_OKAY;
    end else begin
      case (state)
        DEF_IDLE, DEF_ERR2: begin
          // ERR2 is the last data cycle, so a new unmapped access can start here.
          if (take) begin
            state      <= DEF_ERR1;
            err_hready <= 1'b0;
            err_hresp  <= HRESP_ERROR;
          end else begin
            state      <= DEF_IDLE;
            err_hready <= 1'b1;
            err_hresp  <= HRESP_OKAY;
          end
        end
        DEF_ERR1: begin
          state      <= DEF_ERR2;
          err_hready <= 1'b1;
          err_hresp  <= HRESP_ERROR;
        end
        default: begin
          state      <= DEF_IDLE;
          err_hready <= 1'b1;
          err_hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahbl_slave_mux.sv
// Single-master AHB-Lite decoder and slave multiplexer with a built-in ERROR default slave.
// Handshake: a transfer is accepted on a rising clk with m_hready=1; its data phase
// completes on the first later rising edge where m_hready=1 again.
module ahbl_slave_mux
  import ahbl_slave_mux_pkg::*;
#(
  parameter int NUM_SLV        = 15,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_BITS       = 4,
  parameter int SLV_ADDR_WIDTH = 28,
  parameter logic [NUM_SLV-1:0] SLV_EN_MASK = '1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic [ADDR_WIDTH-1:0]                 m_haddr,
  input  logic [2:0]                            m_hburst,
  input  logic [2:0]                            m_hsize,
  input  logic [3:0]                            m_hprot,
  input  logic [1:0]                            m_htrans,
  input  logic                                  m_hwrite,
  input  logic                                  m_hmastlock,
  input  logic [DATA_WIDTH-1:0]                 m_hwdata,
  output logic [DATA_WIDTH-1:0]                 m_hrdata,
  output logic                                  m_hready,
  output logic                                  m_hresp,
  output logic [NUM_SLV-1:0]                    s_hsel,
  output logic [NUM_SLV-1:0][ADDR_WIDTH-1:0]    s_haddr,
  output logic [NUM_SLV-1:0][2:0]               s_hburst,
  output logic [NUM_SLV-1:0][2:0]               s_hsize,
  output logic [NUM_SLV-1:0][3:0]               s_hprot,
  output logic [NUM_SLV-1:0][1:0]               s_htrans,
  output logic [NUM_SLV-1:0]                    s_hwrite,
  output logic [NUM_SLV-1:0][DATA_WIDTH-1:0]    s_hwdata,
  output logic                                  s_hreadyin,
  input  logic [NUM_SLV-1:0]                    s_hready,
  input  logic [NUM_SLV-1:0]                    s_hresp,
  input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0]    s_hrdata
);

  localparam int DEF = NUM_SLV;

  logic [SEL_BITS-1:0]   region;
  logic [ADDR_WIDTH-1:0] fwd_addr;
  logic                  mapped;
  logic                  active;
  logic [NUM_SLV:0]      dsel;
  logic                  dwrite;
  logic                  def_hready;
  logic                  def_hresp;
  def_state_e            def_state;

  assign region   = m_haddr[ADDR_WIDTH-1 -: SEL_BITS];
  assign fwd_addr = ADDR_WIDTH'(m_haddr[SLV_ADDR_WIDTH-1:0]);
  assign active   = is_active(m_htrans);
  assign mapped   = |s_hsel;

  // Address phase: decode and per-port fan-out, parked values on unselected ports.
  always_comb begin
    s_hsel   = '0;
    s_haddr  = '0;
    s_hburst = '0;
    s_hsize  = '0;
    s_hprot  = '0;
    s_htrans = '0;
    s_hwrite = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (region == SEL_BITS'(i) && SLV_EN_MASK[i]) s_hsel[i] = 1'b1;
      if (s_hsel[i]) begin
        s_haddr[i]  = fwd_addr;
        s_hburst[i] = m_hburst;
        s_hsize[i]  = m_hsize;
        s_hprot[i]  = m_hprot;
        s_htrans[i] = m_htrans;
        s_hwrite[i] = m_hwrite;
      end else begin
        s_hsize[i]  = HSIZE_WORD;
        s_htrans[i] = HTRANS_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dsel   <= '0;
      dwrite <= 1'b0;
    end else if (m_hready) begin
      if (active) begin
        dsel   <= {~mapped, s_hsel};
        dwrite <= m_hwrite;
      end else begin
        dsel   <= '0;
        dwrite <= 1'b0;
      end
    end
  end

  ahbl_default_slave u_default_slave (
    .clk        (clk),
    .rstn       (rstn),
    .hsel       (~mapped),
    .htrans     (m_htrans),
    .hready     (m_hready),
    .err_hready (def_hready),
    .err_hresp  (def_hresp),
    .state      (def_state)
  );

  // Data phase: everything here is steered by the registered dsel/dwrite.
  always_comb begin
    m_hready = 1'b1;
    m_hresp  = HRESP_OKAY;
    m_hrdata = '0;
    s_hwdata = '0;
    if (dsel[DEF]) begin
      m_hready = def_hready;
      m_hresp  = def_hresp;
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dsel[i]) begin
        m_hready    = s_hready[i];
        m_hresp     = s_hresp[i];
        s_hwdata[i] = m_hwdata;
        if (!dwrite) m_hrdata = s_hrdata[i];
      end
    end
  end

  assign s_hreadyin = m_hready;

  logic unused_ok;
  assign unused_ok = ^{m_hmastlock, def_state, m_haddr};

endmodule
